// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the data load/store port.
// Owns a word-organised little-endian data RAM and serves one request at a
// time over valid/ready handshakes, with a fixed response latency.
// Also exposes a read-only free-running cycle counter at HC_ADDR.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_write         1 = store, 0 = load
//   req_size          00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned      zero-extend (1) or sign-extend (0) sub-word loads
//   req_addr          byte address
//   req_wdata         right-aligned store data
//   resp_valid/ready  response handshake
//   resp_rdata        extended load data, 0 for stores and errors
//   resp_err          access fault, qualified by resp_valid
//   hc_value          current cycle-counter value
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH   = 15,
  parameter int unsigned READ_LATENCY = 2,
  parameter logic [31:0] HC_ADDR      = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] hc_value
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned LAT_W = 4;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY - 1);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LAT_W-1:0] r_lat;
  logic [LAT_W-1:0] w_lat_nxt;

  logic             r_req_ready;
  logic             r_resp_valid;
  logic [31:0]      r_resp_rdata;
  logic             r_resp_err;
  logic [31:0]      r_hc;

  logic [31:0]      r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_is_hc;
  logic                  w_oor;
  logic                  w_err;
  logic                  w_wr_en;
  logic [1:0]            w_lane;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [31:0]           w_rd_word;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [31:0]           w_load_data;
  logic [31:0]           w_rdata;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata_sh;

  // rst_n gates the accept so a request held during reset cannot write the RAM.
  assign w_accept = req_valid && r_req_ready && rst_n;
  assign w_lane   = req_addr[1:0];
  assign w_idx    = req_addr[ADDR_WIDTH+1:2];
  assign w_is_hc  = (req_addr == HC_ADDR);
  // The counter address lies outside the RAM, so it is exempt from the range check.
  assign w_oor    = !w_is_hc && ((req_addr[31:2] >> ADDR_WIDTH) != 30'd0);

  // Fault classification at accept.
  always_comb begin
    w_err = 1'b0;
    case (req_size)
      SZ_BYTE: w_err = 1'b0;
      SZ_HALF: w_err = w_lane[0];
      SZ_WORD: w_err = (w_lane != 2'b00);
      default: w_err = 1'b1;
    endcase
    if (w_is_hc && ((req_size != SZ_WORD) || req_write)) begin
      w_err = 1'b1;
    end
    if (w_oor) begin
      w_err = 1'b1;
    end
  end

  assign w_rd_word = r_mem[w_idx];

  // Lane extraction and extension of load data.
  always_comb begin
    w_byte      = w_rd_word[7:0];
    w_half      = w_rd_word[15:0];
    w_load_data = w_rd_word;
    case (w_lane)
      2'd1:    w_byte = w_rd_word[15:8];
      2'd2:    w_byte = w_rd_word[23:16];
      2'd3:    w_byte = w_rd_word[31:24];
      default: w_byte = w_rd_word[7:0];
    endcase
    if (w_lane[1]) begin
      w_half = w_rd_word[31:16];
    end
    case (req_size)
      SZ_BYTE: w_load_data = {{24{!req_unsigned && w_byte[7]}}, w_byte};
      SZ_HALF: w_load_data = {{16{!req_unsigned && w_half[15]}}, w_half};
      default: w_load_data = w_rd_word;
    endcase
    if (w_is_hc) begin
      w_load_data = r_hc;
    end
    w_rdata = (w_err || req_write) ? 32'd0 : w_load_data;
  end

  // Byte enables and replicated store data for the addressed lanes.
  always_comb begin
    w_be       = 4'b0000;
    w_wdata_sh = req_wdata;
    case (req_size)
      SZ_BYTE: begin
        w_be       = 4'b0001 << w_lane;
        w_wdata_sh = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_be       = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata_sh = {2{req_wdata[15:0]}};
      end
      SZ_WORD: w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  assign w_wr_en = w_accept && req_write && !w_err;

  // Data RAM; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      if (w_be[0]) r_mem[w_idx][7:0]   <= w_wdata_sh[7:0];
      if (w_be[1]) r_mem[w_idx][15:8]  <= w_wdata_sh[15:8];
      if (w_be[2]) r_mem[w_idx][23:16] <= w_wdata_sh[23:16];
      if (w_be[3]) r_mem[w_idx][31:24] <= w_wdata_sh[31:24];
    end
  end

  // FSM state and latency counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_lat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lat   <= w_lat_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_lat_nxt   = r_lat;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (READ_LATENCY == 1) begin
            w_state_nxt = ST_RESP;
            w_lat_nxt   = '0;
          end else begin
            w_state_nxt = ST_WAIT;
            w_lat_nxt   = LAT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (r_lat <= LAT_W'(1)) begin
          w_state_nxt = ST_RESP;
          w_lat_nxt   = '0;
        end else begin
          w_lat_nxt = r_lat - LAT_W'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_lat_nxt   = '0;
      end
    endcase
  end

  // Registered handshake flags, response payload and cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
      r_hc         <= 32'd0;
    end else begin
      r_hc         <= r_hc + 32'd1;
      r_req_ready  <= (w_state_nxt == ST_IDLE);
      r_resp_valid <= (w_state_nxt == ST_RESP);
      if (w_accept) begin
        r_resp_rdata <= w_rdata;
        r_resp_err   <= w_err;
      end
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign hc_value   = r_hc;

endmodule
